sci_initiator: RTL and testbench

//  Initiator (master) end of the SCI serial configuration link. Converts single parallel register

---
 rtl/sci_pkg.sv | 11 +
 rtl/sci_initiator_shreg.sv | 35 +++
 rtl/sci_initiator.sv | 92 +++++++++
 tb/tb_sci_initiator.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/sci_pkg.sv
// sci_pkg: shared FSM encoding, frame command codes and width helper for the SCI initiator.
package sci_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_WDATA, S_WAIT, S_RDAT, S_FIN} state_t;
  localparam logic CMD_WRITE = 1'b1;
  localparam logic CMD_READ = 1'b0;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/sci_initiator_shreg.sv
// sci_initiator_shreg: MSB-first TX frame shifter and RX data collector for the SCI initiator.
module sci_initiator_shreg #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  load,
  input  logic                  shift,
  input  logic                  cmd,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  cap,
  input  logic                  commit,
  input  logic                  SIN,
  output logic                  msb,
  output logic [DATA_WIDTH-1:0] rdata
);
  localparam int FW = 1 + ADDR_WIDTH + DATA_WIDTH;
  logic [FW-1:0] tx;
  logic [DATA_WIDTH-1:0] rx, rx_nx;
  assign rx_nx = DATA_WIDTH'({rx, SIN});
  assign msb = tx[FW-1];
  // rdata takes the final bit in the same edge that completes the read, so it is valid with DONE.
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) begin
      tx <= '0;
      rx <= '0;
      rdata <= '0;
    end else begin
      tx <= load ? {cmd, addr, wdata} : shift ? {tx[FW-2:0], 1'b0} : tx;
      rx <= cap ? rx_nx : rx;
      rdata <= commit ? rx_nx : rdata;
    end
endmodule

// File: rtl/sci_initiator.sv
// sci_initiator: SCI link master serialising one register write/read per REQ onto CSN/SOUT.
// Define SCI_TIMEOUT_EN to bound WAIT/RDAT to TIMEOUT_CYCLES and pulse ERROR on expiry.
module sci_initiator
  import sci_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  REQ,
  input  logic                  WNR,
  input  logic [ADDR_WIDTH-1:0] ADDR,
  input  logic [DATA_WIDTH-1:0] WDATA,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic                  ERROR,
  output logic                  CSN,
  output logic                  SOUT,
  input  logic                  SIN,
  input  logic                  SACK
);
  localparam int CW = clog2(ADDR_WIDTH > DATA_WIDTH ? ADDR_WIDTH : DATA_WIDTH) + 1;
  state_t state, state_nx;
  logic wnr_q, err_q, tmo, abort, last_a, last_d, tx_bit, shifting, waiting;
  logic [CW-1:0] cnt;
  assign last_a = cnt == CW'(ADDR_WIDTH - 1);
  assign last_d = cnt == CW'(DATA_WIDTH - 1);
  assign shifting = state == S_CMD || state == S_ADDR || state == S_WDATA;
  assign waiting = state == S_WAIT || state == S_RDAT;
  // A timeout only wins when the same cycle does not also complete the reply.
  assign abort = tmo && !(SACK && (state == S_WAIT || last_d));
`ifdef SCI_TIMEOUT_EN
  localparam int TW = clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] tcnt;
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) tcnt <= '0;
    else tcnt <= (state_nx == state && waiting) ? tcnt + 1'b1 : '0;
  assign tmo = waiting && tcnt == TW'(TIMEOUT_CYCLES - 1);
`else
  assign tmo = 1'b0;
`endif
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) begin
      state <= S_IDLE;
      wnr_q <= CMD_READ;
      err_q <= 1'b0;
      cnt <= '0;
    end else begin
      state <= state_nx;
      wnr_q <= (state == S_IDLE && REQ) ? WNR : wnr_q;
      err_q <= abort;
      cnt <= state_nx != state ? CW'(state == S_WAIT)
           : (state == S_ADDR || state == S_WDATA || (state == S_RDAT && SACK)) ? cnt + 1'b1 : cnt;
    end
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  state_nx = REQ ? S_CMD : S_IDLE;
      S_CMD:   state_nx = S_ADDR;
      S_ADDR:  state_nx = last_a ? (wnr_q == CMD_WRITE ? S_WDATA : S_WAIT) : S_ADDR;
      S_WDATA: state_nx = last_d ? S_WAIT : S_WDATA;
      S_WAIT:  state_nx = SACK ? ((wnr_q == CMD_WRITE || DATA_WIDTH == 1) ? S_FIN : S_RDAT)
                        : tmo ? S_FIN : S_WAIT;
      S_RDAT:  state_nx = ((SACK && last_d) || tmo) ? S_FIN : S_RDAT;
      default: state_nx = S_IDLE;
    endcase
  end
  always_comb begin
    BUSY = state != S_IDLE;
    DONE = state == S_FIN;
    ERROR = state == S_FIN && err_q;
    CSN = !(shifting || waiting);
    SOUT = shifting && tx_bit;
  end
  sci_initiator_shreg #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_shreg (
    .CLK(CLK),
    .RSTN(RSTN),
    .load(state == S_IDLE && REQ),
    .shift(shifting),
    .cmd(WNR ? CMD_WRITE : CMD_READ),
    .addr(ADDR),
    .wdata(WDATA),
    .cap(SACK && wnr_q == CMD_READ && waiting),
    .commit(state_nx == S_FIN && wnr_q == CMD_READ && !abort),
    .SIN(SIN),
    .msb(tx_bit),
    .rdata(RDATA)
  );
endmodule

// File: tb/tb_sci_initiator.sv
// tb_sci_initiator: randomized SCI transactions against a frame-level responder and a timing model.
module tb_sci_initiator;
  localparam int AW = 4, DW = 8, TO = 64;
  logic CLK = 0, RSTN = 0, REQ = 0, WNR = 0, SIN = 0, SACK = 0;
  logic [AW-1:0] ADDR = '0;
  logic [DW-1:0] WDATA = '0;
  logic BUSY, DONE, ERROR, CSN, SOUT;
  logic [DW-1:0] RDATA;

  sci_initiator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RSTN(RSTN), .REQ(REQ), .WNR(WNR), .ADDR(ADDR), .WDATA(WDATA),
    .BUSY(BUSY), .DONE(DONE), .RDATA(RDATA), .ERROR(ERROR),
    .CSN(CSN), .SOUT(SOUT), .SIN(SIN), .SACK(SACK)
  );

  always #5 CLK = ~CLK;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
  endtask

  // Transaction model: what the pins must do, relative to the REQ cycle.
  bit act = 0, m_w = 0, m_sil = 0, chk_en = 0;
  int t_req = 0, dur = 0, flen = 0;
  logic [31:0] fbits = '0;
  logic [DW-1:0] m_resp = '0, rd_prev = '0;

  // Responder configuration and state.
  int r_d = 0, r_sa = DW, r_sl = 0;
  bit r_sil = 0;
  logic [DW-1:0] r_resp = '0;
  bit in_frame = 0, cmd_bit = 0, acked = 0;
  int rx_n = 0, wc = 0, sent = 0, gap = 0;
  logic [31:0] rx_frame = '0;

  initial begin : responder
    forever begin
      @(posedge CLK); #1;
      if (CSN) begin
        in_frame = 0;
        SACK = 1'($urandom_range(0, 1));
        SIN = 1'($urandom_range(0, 1));
      end else begin
        if (!in_frame) begin
          in_frame = 1; rx_n = 0; rx_frame = '0; wc = 0; sent = 0; gap = 0; acked = 0;
        end
        if (rx_n == 0 || rx_n < (cmd_bit ? 1 + AW + DW : 1 + AW)) begin
          if (rx_n == 0) cmd_bit = SOUT;
          rx_frame = {rx_frame[30:0], SOUT};
          rx_n++;
          SACK = 1'($urandom_range(0, 1));
          SIN = 1'($urandom_range(0, 1));
        end else if (r_sil || wc < r_d) begin
          SACK = 0; SIN = 1'($urandom_range(0, 1)); wc++;
        end else if (cmd_bit) begin
          SACK = !acked; acked = 1;
        end else if (sent < DW && sent == r_sa && gap < r_sl) begin
          SACK = 0; SIN = 1'($urandom_range(0, 1)); gap++;
        end else if (sent < DW) begin
          SACK = 1; SIN = r_resp[DW-1-sent]; sent++;
        end else begin
          SACK = 0;
        end
      end
    end
  end

  always @(negedge CLK) if (chk_en) begin : cmp
    int k;
    k = cyc - t_req;
    chk("BUSY", BUSY, act && k >= 1 && k <= dur);
    chk("DONE", DONE, act && k == dur);
    chk("CSN", CSN, !(act && k >= 1 && k < dur));
    chk("SOUT", SOUT, (act && k >= 1 && k <= flen) ? fbits[flen-k] : 1'b0);
    chk("ERROR", ERROR, act && m_sil && k == dur);
    chk("RDATA", RDATA, (act && !m_w && !m_sil && k >= dur) ? m_resp : rd_prev);
  end

  task automatic start(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input logic [DW-1:0] rs, input int d, input int sa, input int sl, input bit sil);
    r_d = d; r_sa = sa; r_sl = sl; r_sil = sil; r_resp = rs;
    m_w = w; m_sil = sil; m_resp = rs;
    flen = w ? 1 + AW + DW : 1 + AW;
    fbits = w ? 32'({1'b1, a, wd}) : 32'({1'b0, a});
    dur = sil ? 2 + AW + (w ? DW : 0) + TO
        : w ? 2 + AW + DW + d + 1 : 2 + AW + d + DW + (sa < DW ? sl : 0);
    @(posedge CLK); #1;
    REQ = 1; WNR = w; ADDR = a; WDATA = wd; t_req = cyc; act = 1;
    @(posedge CLK); #1;
    REQ = 0; WNR = 1'($urandom_range(0, 1)); ADDR = AW'($urandom); WDATA = DW'($urandom);
  endtask

  task automatic finish(output int meas, output logic [DW-1:0] rd_done, output logic csn_done);
    int waited = 0;
    while (!DONE && waited < 300) begin
      @(negedge CLK);
      waited++;
    end
    chk("done_seen", waited < 300, 1);
    meas = cyc - t_req;
    rd_done = RDATA;
    csn_done = CSN;
    chk("frame_len", rx_n, flen);
    chk("frame_bits", rx_frame, fbits);
    @(posedge CLK); #1;
    act = 0;
    if (!m_w && !m_sil) rd_prev = m_resp;
  endtask

  task automatic txn(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                     input logic [DW-1:0] rs, input int d, input int sa, input int sl,
                     input bit pulse, input bit sil,
                     output int meas, output logic [DW-1:0] rd_done, output logic csn_done);
    start(w, a, wd, rs, d, sa, sl, sil);
    if (pulse) begin
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      REQ = 1; WNR = !w; ADDR = AW'($urandom);
      @(posedge CLK); #1;
      REQ = 0;
    end
    finish(meas, rd_done, csn_done);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin : main
    int m;
    logic [DW-1:0] rd;
    logic cs;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_CSN", CSN, 1);
    chk("rst_SOUT", SOUT, 0);
    chk("rst_BUSY", BUSY, 0);
    chk("rst_DONE", DONE, 0);
    chk("rst_ERROR", ERROR, 0);
    chk("rst_RDATA", RDATA, 0);
    @(posedge CLK); #1;
    RSTN = 1; chk_en = 1;
    txn(1, 4'h3, 8'hA5, 8'h00, 2, DW, 0, 0, 0, m, rd, cs);
    chk("wr_latency", m, 17);
    chk("wr_frame", rx_frame, 32'h13A5);
    chk("wr_rdata_kept", rd, 0);
    txn(0, 4'h8, 8'h00, 8'h5C, 0, DW, 0, 0, 0, m, rd, cs);
    chk("rd_latency", m, 14);
    chk("rd_frame", rx_frame, 32'h08);
    chk("rd_rdata", rd, 8'h5C);
    chk("rd_csn_fin", cs, 1);
    txn(0, 4'h8, 8'h33, 8'h5C, 0, 4, 3, 0, 0, m, rd, cs);
    chk("stall_latency", m, 17);
    chk("stall_rdata", rd, 8'h5C);
    txn(1, 4'h6, 8'h3C, 8'h00, 1, DW, 0, 1, 0, m, rd, cs);
    chk("pulse_latency", m, 16);
    chk("pulse_rdata_kept", rd, 8'h5C);
    repeat (30) @(posedge CLK);
    #1;
    start(1, 4'h2, 8'h77, 8'h00, 0, DW, 0, 0);
    @(posedge CLK); #1;
    chk_en = 0; RSTN = 0;
    #1;
    chk("arst_CSN", CSN, 1);
    chk("arst_BUSY", BUSY, 0);
    chk("arst_RDATA", RDATA, 0);
    @(posedge CLK); #1;
    RSTN = 1; act = 0; rd_prev = '0; chk_en = 1;
    txn(1, 4'h1, 8'h01, 8'h00, 0, DW, 0, 0, 0, m, rd, cs);
    chk("post_rst_latency", m, 15);
    chk("post_rst_frame", rx_frame, 32'h1101);
    for (int i = 0; i < 24; i++) begin
      txn(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom), DW'($urandom),
          $urandom_range(0, 4), $urandom_range(0, DW), $urandom_range(0, 3),
          1'($urandom_range(0, 1)), 0, m, rd, cs);
      repeat ($urandom_range(0, 3)) begin
        @(posedge CLK); #1;
      end
    end
`ifdef SCI_TIMEOUT_EN
    begin
      logic [DW-1:0] keep;
      keep = rd_prev;
      txn(0, 4'hA, 8'h00, 8'hFF, 0, DW, 0, 0, 1, m, rd, cs);
      chk("tmo_latency", m, 2 + AW + TO);
      chk("tmo_rdata_kept", rd, keep);
    end
`endif
    repeat (3) @(posedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
